// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared constants for the main-memory port arbiter: default
//               line/address widths and the 3-bit FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int c_addr_w_def = 14;   // line address (word address >> 2)
    localparam int c_line_w_def = 64;   // 4 x 16-bit words

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_i_rd = 3'd1;
    localparam logic [2:0] c_st_d_rd = 3'd2;
    localparam logic [2:0] c_st_d_wr = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/arb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : arb_timeout_ctr
// Description : Loadable up-counter with a terminal flag, used to bound how
//               long a transaction may wait for its completion strobe.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_load       - load i_load_val (takes priority over i_en)
//               i_load_val   - value to load
//               i_en         - count enable
//               o_term       - high while enabled and count == TERM
// Revision    : 1.0 - initial release
// ============================================================================
module arb_timeout_ctr #(
    parameter int WIDTH = 8,
    parameter int TERM  = 254
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_term
);

    localparam logic [WIDTH-1:0] c_term = WIDTH'(TERM);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    // Flag only while counting so an idle counter never signals expiry.
    assign o_term = i_en && (r_count == c_term);

endmodule : arb_timeout_ctr
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares the single main-memory port between I-cache fills and
//               D-cache fills/evictions. One transaction at a time; strobes,
//               address and write data are held until mem_rdy; a one-cycle
//               ack returns the registered line. Bounds I-side starvation and
//               flags a hung memory with a sticky mem_err.
// Ports       : clk, rst                - clock, sync active-high reset
//               i_req/i_addr            - I fill request (level) and address
//               i_ack/i_rdata           - I completion pulse and fill line
//               d_re/d_we/d_addr/d_wdata- D fill / eviction request
//               d_ack/d_rdata           - D completion pulse and fill line
//               mem_re/mem_we/mem_addr/mem_wdata - memory request side
//               mem_rdata/mem_rdy       - memory response side
//               mem_err                 - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = c_addr_w_def,
    parameter int LINE_W      = c_line_w_def,
    parameter int D_BURST_MAX = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_rdy,
    output logic              mem_err
);

    localparam int                   c_burst_w   = $clog2(D_BURST_MAX + 2);
    localparam logic [c_burst_w-1:0] c_burst_max = c_burst_w'(D_BURST_MAX);
    localparam int                   c_tmo_w     = $clog2(TIMEOUT + 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [c_burst_w-1:0] r_burst;
    logic                 r_i_ack, r_d_ack, r_mem_re, r_mem_we, r_mem_err;
    logic [LINE_W-1:0]    r_i_rdata, r_d_rdata, r_mem_wdata;
    logic [ADDR_W-1:0]    r_mem_addr;

    logic w_busy, w_cnt_en, w_tmo, w_d_want;
    logic w_grant_i, w_grant_dw, w_grant_dr;

    assign w_busy   = (r_state == c_st_i_rd) || (r_state == c_st_d_rd) ||
                      (r_state == c_st_d_wr);
    assign w_cnt_en = w_busy && !mem_rdy;
    assign w_d_want = d_re || d_we;

    // Counts wait cycles of the current transaction; reloaded to zero on any
    // cycle it is not counting, which covers every state exit.
    arb_timeout_ctr #(
        .WIDTH (c_tmo_w),
        .TERM  (TIMEOUT - 1)
    ) u_tmo (
        .clk        (clk),
        .rst        (rst),
        .i_load     (!w_cnt_en || w_tmo),
        .i_load_val ('0),
        .i_en       (w_cnt_en),
        .o_term     (w_tmo)
    );

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_dw   = 1'b0;
        w_grant_dr   = 1'b0;
        case (r_state)
            c_st_idle: begin
                // D side normally wins; a waiting I request wins once D has
                // taken D_BURST_MAX grants in a row while I was waiting.
                if (i_req && (!w_d_want || r_burst == c_burst_max)) begin
                    w_grant_i    = 1'b1;
                    w_next_state = c_st_i_rd;
                end else if (d_we) begin
                    w_grant_dw   = 1'b1;
                    w_next_state = c_st_d_wr;
                end else if (d_re) begin
                    w_grant_dr   = 1'b1;
                    w_next_state = c_st_d_rd;
                end
            end
            c_st_i_rd, c_st_d_rd, c_st_d_wr: begin
                if (mem_rdy || w_tmo) w_next_state = c_st_done;
            end
            // One dead cycle so a still-held request level is not re-granted
            // before the requester has seen its ack.
            c_st_done: w_next_state = c_st_idle;
            default:   w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_burst     <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_i_ack <= 1'b0;
            r_d_ack <= 1'b0;
            if (r_state == c_st_idle) begin
                if (w_grant_i) begin
                    r_mem_re   <= 1'b1;
                    r_mem_addr <= i_addr;
                end else if (w_grant_dw) begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= d_addr;
                    r_mem_wdata <= d_wdata;
                end else if (w_grant_dr) begin
                    r_mem_re   <= 1'b1;
                    r_mem_addr <= d_addr;
                end
                if (w_grant_i || !i_req) begin
                    r_burst <= '0;
                end else if ((w_grant_dw || w_grant_dr) && r_burst != c_burst_max) begin
                    r_burst <= r_burst + c_burst_w'(1);
                end
            end else if (w_busy && (mem_rdy || w_tmo)) begin
                // Completion or expiry: drop strobes, ack the owner. On expiry
                // the returned line is zero and mem_err latches.
                r_mem_re <= 1'b0;
                r_mem_we <= 1'b0;
                if (w_tmo) r_mem_err <= 1'b1;
                if (r_state == c_st_i_rd) begin
                    r_i_ack   <= 1'b1;
                    r_i_rdata <= mem_rdy ? mem_rdata : '0;
                end else begin
                    r_d_ack <= 1'b1;
                    if (r_state == c_st_d_rd || w_tmo) begin
                        r_d_rdata <= mem_rdy ? mem_rdata : '0;
                    end
                end
            end
        end
    end

    assign i_ack     = r_i_ack;
    assign i_rdata   = r_i_rdata;
    assign d_ack     = r_d_ack;
    assign d_rdata   = r_d_rdata;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_err   = r_mem_err;

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               reference (in-flight kind, wait age, D streak) predicts every
//               output each cycle; directed scenarios add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W      = 14;
    localparam int LINE_W      = 64;
    localparam int D_BURST_MAX = 4;
    localparam int TIMEOUT     = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0, d_re = 1'b0, d_we = 1'b0, mem_rdy = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0, d_addr = '0;
    logic [LINE_W-1:0] d_wdata = '0, mem_rdata = '0;
    logic              i_ack, d_ack, mem_re, mem_we, mem_err;
    logic [LINE_W-1:0] i_rdata, d_rdata, mem_wdata;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W),
        .D_BURST_MAX(D_BURST_MAX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
        .mem_err(mem_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (updates on each rising edge) --------
    int          m_kind   = 0;   // 0 none, 1 I fill, 2 D fill, 3 D eviction
    int          m_age    = 0;   // cycles waited without mem_rdy
    int          m_streak = 0;   // D grants in a row while I waited
    bit          m_cool   = 1'b0;
    bit          m_late;
    bit          started  = 1'b0;
    logic [63:0] m_line;
    logic        e_i_ack = 0, e_d_ack = 0, e_re = 0, e_we = 0, e_err = 0;
    logic [ADDR_W-1:0] e_addr = '0;
    logic [63:0] e_wdata = '0, e_irdata = '0, e_drdata = '0;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_kind = 0; m_age = 0; m_streak = 0; m_cool = 1'b0;
            e_i_ack = 0; e_d_ack = 0; e_re = 0; e_we = 0; e_err = 0;
            e_addr = '0; e_wdata = '0; e_irdata = '0; e_drdata = '0;
        end else begin
            e_i_ack = 0;
            e_d_ack = 0;
            if (m_kind != 0) begin
                m_late = !mem_rdy && (m_age + 1 == TIMEOUT);
                if (!mem_rdy) m_age++;
                if (mem_rdy || m_late) begin
                    m_line = m_late ? 64'd0 : mem_rdata;
                    if (m_late) e_err = 1;
                    if (m_kind == 1) begin
                        e_i_ack = 1; e_irdata = m_line;
                    end else begin
                        e_d_ack = 1;
                        if (m_kind == 2 || m_late) e_drdata = m_line;
                    end
                    e_re = 0; e_we = 0; m_kind = 0; m_age = 0; m_cool = 1'b1;
                end
            end else if (m_cool) begin
                m_cool = 1'b0;
            end else if (i_req && (!(d_re || d_we) || m_streak == D_BURST_MAX)) begin
                m_kind = 1; e_re = 1; e_addr = i_addr; m_streak = 0;
            end else if (d_re || d_we) begin
                m_kind = d_we ? 3 : 2;
                e_re = !d_we; e_we = d_we; e_addr = d_addr;
                if (d_we) e_wdata = d_wdata;
                m_streak = !i_req ? 0 : (m_streak < D_BURST_MAX ? m_streak + 1 : m_streak);
            end else begin
                m_streak = 0;
            end
        end
    end

    // ---------------- per-cycle compare on the falling edge ----------------
    always @(negedge clk) begin
        if (started) begin
            chk("i_ack", i_ack, e_i_ack);
            chk("d_ack", d_ack, e_d_ack);
            chk("mem_re", mem_re, e_re);
            chk("mem_we", mem_we, e_we);
            chk("mem_err", mem_err, e_err);
            chk("i_rdata", i_rdata, e_irdata);
            chk("d_rdata", d_rdata, e_drdata);
            if (e_re || e_we) chk("mem_addr", mem_addr, e_addr);
            if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
        end
    end

    int n_dack = 0;
    always @(negedge clk) if (d_ack === 1'b1) n_dack++;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a strobe, hold it lat extra cycles, then complete.
    // Returns with the ack cycle current.
    task automatic mem_serve(input int lat, input logic [63:0] line,
                             output logic was_we, output logic [ADDR_W-1:0] a_seen,
                             output logic [63:0] w_seen);
        int guard = 0;
        while (!(mem_re || mem_we) && guard < 50) begin
            tick();
            guard++;
        end
        chk("strobe_seen", mem_re | mem_we, 1);
        was_we = mem_we; a_seen = mem_addr; w_seen = mem_wdata;
        repeat (lat) tick();
        mem_rdy = 1'b1; mem_rdata = line;
        tick();
        mem_rdy = 1'b0; mem_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic              was_we;
        logic [ADDR_W-1:0] a_seen;
        logic [63:0]       w_seen;
        int                n0;
        int                guard;

        // Reset state
        repeat (3) tick();
        chk("rst_mem_re", mem_re, 0);
        chk("rst_i_ack", i_ack, 0);
        chk("rst_mem_err", mem_err, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        tick();

        // Isolated I fill: request t0, mem_rdy t3, ack t4
        i_req = 1'b1; i_addr = 14'h0040;
        tick();
        chk("t1_mem_re", mem_re, 1);
        chk("t1_mem_addr", mem_addr, 14'h0040);
        tick();
        chk("t2_mem_re", mem_re, 1);
        tick();
        chk("t3_mem_re", mem_re, 1);
        chk("t3_i_ack", i_ack, 0);
        mem_rdy = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        tick();
        mem_rdy = 1'b0; mem_rdata = '0;
        chk("t4_i_ack", i_ack, 1);
        chk("t4_i_rdata", i_rdata, 64'h1111_2222_3333_4444);
        chk("t4_mem_re", mem_re, 0);
        i_req = 1'b0;

        // D and I together: D first, then I
        d_re = 1'b1; d_addr = 14'h0200;
        i_req = 1'b1; i_addr = 14'h0300;
        mem_serve(1, 64'hAAAA_0000_AAAA_0001, was_we, a_seen, w_seen);
        chk("arb_first_addr", a_seen, 14'h0200);
        chk("arb_d_ack", d_ack, 1);
        chk("arb_d_rdata", d_rdata, 64'hAAAA_0000_AAAA_0001);
        d_re = 1'b0;
        mem_serve(0, 64'hBBBB_0000_BBBB_0002, was_we, a_seen, w_seen);
        chk("arb_second_addr", a_seen, 14'h0300);
        chk("arb_i_ack", i_ack, 1);
        i_req = 1'b0;

        // Eviction then fill at 0x0123
        n0 = n_dack;
        d_we = 1'b1; d_re = 1'b1; d_addr = 14'h0123; d_wdata = 64'hDEAD_BEEF_0123_4567;
        mem_serve(2, 64'h0, was_we, a_seen, w_seen);
        chk("evict_is_write", was_we, 1);
        chk("evict_addr", a_seen, 14'h0123);
        chk("evict_wdata", w_seen, 64'hDEAD_BEEF_0123_4567);
        chk("evict_d_ack", d_ack, 1);
        d_we = 1'b0;
        mem_serve(1, 64'hCAFE_F00D_0000_0123, was_we, a_seen, w_seen);
        chk("fill_is_read", was_we, 0);
        chk("fill_addr", a_seen, 14'h0123);
        chk("fill_d_rdata", d_rdata, 64'hCAFE_F00D_0000_0123);
        d_re = 1'b0;
        tick(); tick();
        chk("two_d_acks", n_dack - n0, 2);

        // Starvation bound: four D grants, fifth to I
        i_req = 1'b1; i_addr = 14'h0444;
        d_re = 1'b1; d_addr = 14'h0500;
        for (int k = 0; k < 4; k++) begin
            mem_serve(0, 64'h5000 + 64'(k), was_we, a_seen, w_seen);
            chk("burst_d_addr", a_seen, 14'h0500 + 14'(k));
            chk("burst_d_ack", d_ack, 1);
            d_addr = d_addr + 14'd1;
        end
        mem_serve(0, 64'h1234_5678_9ABC_DEF0, was_we, a_seen, w_seen);
        chk("starve_i_addr", a_seen, 14'h0444);
        chk("starve_i_ack", i_ack, 1);
        chk("starve_no_d_ack", d_ack, 0);
        i_req = 1'b0;
        mem_serve(0, 64'h5004, was_we, a_seen, w_seen);
        chk("after_starve_addr", a_seen, 14'h0504);
        d_re = 1'b0;

        // Timeout: mem_rdy never comes for the I fill
        i_req = 1'b1; i_addr = 14'h0555;
        guard = 0;
        while (!mem_re && guard < 20) begin
            tick();
            guard++;
        end
        chk("tmo_strobe_seen", mem_re, 1);
        for (int c = 1; c <= TIMEOUT; c++) begin
            chk("tmo_err_low", mem_err, 0);
            chk("tmo_re_held", mem_re, 1);
            tick();
        end
        chk("tmo_err_set", mem_err, 1);
        chk("tmo_i_ack", i_ack, 1);
        chk("tmo_i_rdata_zero", i_rdata, 0);
        chk("tmo_re_dropped", mem_re, 0);
        i_req = 1'b0;
        d_re = 1'b1; d_addr = 14'h0666;
        mem_serve(1, 64'h6666_6666_6666_6666, was_we, a_seen, w_seen);
        chk("post_tmo_addr", a_seen, 14'h0666);
        chk("post_tmo_d_rdata", d_rdata, 64'h6666_6666_6666_6666);
        chk("post_tmo_err_sticky", mem_err, 1);
        d_re = 1'b0;
        tick();

        // Reset in the middle of a D fill
        d_re = 1'b1; d_addr = 14'h0777;
        tick();
        chk("rstmid_re", mem_re, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_mem_re", mem_re, 0);
        chk("rstmid_mem_addr", mem_addr, 0);
        chk("rstmid_d_ack", d_ack, 0);
        chk("rstmid_mem_err", mem_err, 0);
        chk("rstmid_i_rdata", i_rdata, 0);
        rst = 1'b0; d_re = 1'b0;
        tick();
        mem_rdy = 1'b1; mem_rdata = 64'h7777_7777_7777_7777;
        tick();
        mem_rdy = 1'b0; mem_rdata = '0;
        chk("stray_rdy_no_ack", d_ack, 0);
        tick();
        chk("stray_rdy_no_ack2", d_ack, 0);
        chk("stray_rdy_d_rdata", d_rdata, 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
